turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
Turn controller for the snakes-and-ladders game. It takes roll requests for 2-4 players in round-robin order. For each accepted roll it samples the dice generator's output, applies the move with board bounds and snake/ladder jumps, detects the winner, and drives the one-hot winner bus back to the dice generator to freeze it.

Parameters:
NUM_PLAYERS, 2, number of players; legal range 2..4.
LAST_SQ, 99, final square index; squares are 0..LAST_SQ.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
roll_req  input  1  one-cycle pulse, already debounced and synchronised; current player rolls
dice_value  input  4  dice generator output; legal values are 1..6
dice_clear_n  output  1  active-low clear to dice generator; 0 during reset and in WIN
cur_player  output  2  index of the player whose turn it is
positions  output  7*NUM_PLAYERS  packed positions; player i at bits [7i+6:7i]
last_roll  output  3  most recent accepted dice value
turn_done  output  1  one-cycle pulse when a move completes
winner  output  4  one-hot winner; bit i set means player i won; 0 while no winner

Behaviour:
- Reset (synchronous, active-high): state WAIT, cur_player 0, all positions 0, last_roll 0, turn_done 0, winner 0, dice_clear_n 0. Reset asserted mid-move aborts the move and leaves no partial update.
- States:
  - WAIT: on roll_req with dice_value in 1..6, latch it into last_roll and go to ADD. If dice_value is 0 or 7 (generator wrap glitch), set a pending flag, stay in WAIT, and sample again each cycle until legal. Clear the pending flag when the roll is accepted.
  - ADD: if pos + dice <= LAST_SQ, pos <= pos + dice; otherwise pos is unchanged (overshoot means no move). Go to JUMP.
  - JUMP: pos <= jump(pos) using the board lookup; squares with no entry map to themselves. Go to CHECK.
  - CHECK: assert turn_done for exactly one cycle. If pos == LAST_SQ, set winner = 1<<cur_player and go to WIN. Otherwise set cur_player to (cur_player+1) mod NUM_PLAYERS and go to WAIT.
  - WIN: terminal. roll_req is ignored and dice_clear_n is 0. Exit only by reset.
- roll_req outside WAIT is dropped; it is not queued.
- Latency: with roll_req accepted in cycle T, the add result is visible in T+1, the jump result in T+2, turn_done and winner in T+3, and the next player's WAIT begins in T+4.
- Arithmetic: 8-bit add internally, so 99+6 does not wrap; compare against LAST_SQ before writing back. Positions are 7 bits.
- Only one player's position changes per turn.
- The jump table has no chaining: a destination is never itself a jump source.

Optional Feature:
EXTRA_TURN_ON_SIX_EN
- When defined: in CHECK, if last_roll == 6 and there is no win, cur_player is held, so the same player rolls again. Extra turns are unlimited.
- When undefined: cur_player always advances; last_roll has no effect on turn order.

Decomposition:
- Shared package snl_pkg holds:
  - state enum: WAIT, ADD, JUMP, CHECK, WIN
  - POS_W = 7 and LAST_SQ default
  - jump table constants: ladders 3->21, 8->30, 27->55; snakes 46->18, 62->24, 98->40
- Sub-module board_jump_rom: combinational, 7-bit square in, 7-bit square out, built from the package constants. It is shared with the display logic.

Test Plan:
- Reset, then roll_req with dice=4, NUM_PLAYERS=2 -> positions[6:0]=4 at T+2, turn_done at T+3, cur_player=1.
- Player 0 at 0 rolls 3 -> 21 (ladder) at T+2. Player at 40 rolls 6 -> 18 (snake).
- Player at 97 rolls 5 -> stays 97 (overshoot). Player at 95 rolls 4 -> 99, winner=4'b0001 at T+3, dice_clear_n=0, later roll_req has no effect.
- Hold dice=7 while roll_req fires, then dice=2 next cycle -> roll accepted with last_roll=2, no move occurs on the 7.
- Assert reset during JUMP -> next cycle all positions 0, cur_player 0, winner 0. A roll_req during ADD/JUMP/CHECK is dropped.
- With EXTRA_TURN_ON_SIX_EN, player 1 rolls 6 -> cur_player stays 1. Without the macro, cur_player becomes 0.

Source files
------------

// File: rtl/snl_pkg.sv
// snl_pkg: shared state encoding, board geometry and snake/ladder table for the turn scheduler.
package snl_pkg;
  typedef enum logic [2:0] {WAIT, ADD, JUMP, CHECK, WIN} state_t;
  localparam int POS_W = 7;
  localparam int LAST_SQ_DEFAULT = 99;
  localparam int NUM_JUMPS = 6;
  // Entry 0 is the rightmost element; ladders first, then snakes.
  localparam logic [NUM_JUMPS-1:0][POS_W-1:0] JUMP_SRC = {7'd98, 7'd62, 7'd46, 7'd27, 7'd8, 7'd3};
  localparam logic [NUM_JUMPS-1:0][POS_W-1:0] JUMP_DST = {7'd40, 7'd24, 7'd18, 7'd55, 7'd30, 7'd21};
endpackage

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if: dice-generator/game-side bus of the turn scheduler; the scheduler uses the slave modport.
interface turn_scheduler_if import snl_pkg::*; #(parameter int NUM_PLAYERS = 2);
  logic roll_req;
  logic [3:0] dice_value;
  logic dice_clear_n;
  logic [1:0] cur_player;
  logic [POS_W*NUM_PLAYERS-1:0] positions;
  logic [2:0] last_roll;
  logic turn_done;
  logic [3:0] winner;
  modport master(output roll_req, dice_value,
                 input dice_clear_n, cur_player, positions, last_roll, turn_done, winner);
  modport slave(input roll_req, dice_value,
                output dice_clear_n, cur_player, positions, last_roll, turn_done, winner);
endinterface

// File: rtl/board_jump_rom.sv
// board_jump_rom: maps a square to its snake/ladder destination; squares without an entry map to themselves.
module board_jump_rom import snl_pkg::*; (
  input  logic [POS_W-1:0] sq,
  output logic [POS_W-1:0] dst
);
  always_comb begin
    dst = sq;
    for (int i = 0; i < NUM_JUMPS; i++) dst = (sq == JUMP_SRC[i]) ? JUMP_DST[i] : dst;
  end
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: round-robin snakes-and-ladders turn FSM (WAIT/ADD/JUMP/CHECK/WIN).
// Define EXTRA_TURN_ON_SIX_EN to let a player who rolls a 6 roll again.
module turn_scheduler import snl_pkg::*; #(
  parameter int NUM_PLAYERS = 2,
  parameter int LAST_SQ = LAST_SQ_DEFAULT
) (
  input logic clock,
  input logic reset,
  turn_scheduler_if.slave bus
);
  localparam logic [POS_W-1:0] LAST = POS_W'(LAST_SQ);
  state_t state, state_nx;
  logic pending, legal, accept, hold;
  logic [NUM_PLAYERS-1:0][POS_W-1:0] pos;
  logic [POS_W-1:0] cur_pos, jump_pos;
  logic [POS_W:0] sum;
  logic [1:0] cur_player, next_player;
  logic [2:0] last_roll;
  logic turn_done;
  logic [3:0] winner;
  board_jump_rom rom (.sq(cur_pos), .dst(jump_pos));
  assign legal = bus.dice_value inside {[4'd1:4'd6]};
  // A glitched sample keeps the request alive so the next legal value is taken without a new pulse.
  assign accept = state == WAIT && (bus.roll_req || pending) && legal;
  assign sum = {1'b0, cur_pos} + {5'b0, last_roll};
  assign next_player = (cur_player == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_player + 2'd1;
`ifdef EXTRA_TURN_ON_SIX_EN
  assign hold = last_roll == 3'd6;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) cur_pos = (cur_player == 2'(i)) ? pos[i] : cur_pos;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == WAIT  ? (accept ? ADD : WAIT) :
               state == ADD   ? JUMP :
               state == JUMP  ? CHECK :
               state == CHECK ? (cur_pos == LAST ? WIN : WAIT) : WIN;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT;
      pending <= 1'b0;
      pos <= '0;
      cur_player <= 2'd0;
      last_roll <= 3'd0;
      turn_done <= 1'b0;
      winner <= 4'd0;
    end else begin
      state <= state_nx;
      turn_done <= state == CHECK;
      if (state == WAIT) pending <= (pending || bus.roll_req) && !legal;
      if (accept) last_roll <= bus.dice_value[2:0];
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (cur_player == 2'(i) && state == ADD && sum <= {1'b0, LAST}) pos[i] <= sum[POS_W-1:0];
        if (cur_player == 2'(i) && state == JUMP) pos[i] <= jump_pos;
      end
      if (state == CHECK && cur_pos == LAST) winner <= 4'b1 << cur_player;
      if (state == CHECK && cur_pos != LAST && !hold) cur_player <= next_player;
    end
  end
  assign bus.dice_clear_n = !(reset || state == WIN);
  assign bus.cur_player = cur_player;
  assign bus.positions = pos;
  assign bus.last_roll = last_roll;
  assign bus.turn_done = turn_done;
  assign bus.winner = winner;
endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: table-driven game replay plus hand sequences for glitch, reset-in-JUMP and six handling.
module tb_turn_scheduler;
  import snl_pkg::*;
`ifdef EXTRA_TURN_ON_SIX_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif
  typedef struct {
    int player;
    int dice;
    int add_pos;
    int jump_pos;
    int win;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  vec_t tbl[26];
  int exp_pos[2];
  always #5 clock = ~clock;
  turn_scheduler_if #(.NUM_PLAYERS(2)) bus();
  turn_scheduler #(.NUM_PLAYERS(2), .LAST_SQ(99)) dut (.clock(clock), .reset(reset), .bus(bus));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [6:0] pos_of(input int i);
    return bus.positions[7*i +: 7];
  endfunction
  task automatic roll(input logic [3:0] d);
    bus.roll_req = 1'b1;
    bus.dice_value = d;
    tick();
    bus.roll_req = 1'b0;
    bus.dice_value = 4'd0;
    tick();
    tick();
    tick();
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    tbl[0]  = '{0, 4,  4,  4, 0};
    tbl[1]  = '{1, 3,  3, 21, 0};
    tbl[2]  = '{0, 4,  8, 30, 0};
    tbl[3]  = '{1, 5, 26, 26, 0};
    tbl[4]  = '{0, 3, 33, 33, 0};
    tbl[5]  = '{1, 1, 27, 55, 0};
    tbl[6]  = '{0, 5, 38, 38, 0};
    tbl[7]  = '{1, 5, 60, 60, 0};
    tbl[8]  = '{0, 3, 41, 41, 0};
    tbl[9]  = '{1, 5, 65, 65, 0};
    tbl[10] = '{0, 5, 46, 18, 0};
    tbl[11] = '{1, 5, 70, 70, 0};
    tbl[12] = '{0, 5, 23, 23, 0};
    tbl[13] = '{1, 5, 75, 75, 0};
    tbl[14] = '{0, 5, 28, 28, 0};
    tbl[15] = '{1, 5, 80, 80, 0};
    tbl[16] = '{0, 5, 33, 33, 0};
    tbl[17] = '{1, 5, 85, 85, 0};
    tbl[18] = '{0, 5, 38, 38, 0};
    tbl[19] = '{1, 5, 90, 90, 0};
    tbl[20] = '{0, 5, 43, 43, 0};
    tbl[21] = '{1, 5, 95, 95, 0};
    tbl[22] = '{0, 5, 48, 48, 0};
    tbl[23] = '{1, 5, 95, 95, 0};
    tbl[24] = '{0, 5, 53, 53, 0};
    tbl[25] = '{1, 4, 99, 99, 2};
    bus.roll_req = 1'b0;
    bus.dice_value = 4'd0;
    tick();
    tick();
    check("clear_n_in_reset", bus.dice_clear_n, 0);
    reset = 1'b0;
    tick();
    check("rst_cur_player", bus.cur_player, 0);
    check("rst_positions", bus.positions, 0);
    check("rst_last_roll", bus.last_roll, 0);
    check("rst_turn_done", bus.turn_done, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_clear_n", bus.dice_clear_n, 1);
    // Glitched dice values are not accepted; the pending request takes the first legal value.
    bus.roll_req = 1'b1;
    bus.dice_value = 4'd7;
    tick();
    bus.roll_req = 1'b0;
    check("glitch7_no_accept", bus.last_roll, 0);
    bus.dice_value = 4'd0;
    tick();
    check("glitch0_no_accept", bus.last_roll, 0);
    check("glitch_no_move", bus.positions, 0);
    bus.dice_value = 4'd2;
    tick();
    check("glitch_then_accept", bus.last_roll, 2);
    bus.dice_value = 4'd5;
    tick();
    check("glitch_add", pos_of(0), 2);
    tick();
    tick();
    check("glitch_turn_done", bus.turn_done, 1);
    check("glitch_next_player", bus.cur_player, 1);
    tick();
    check("pending_cleared", bus.last_roll, 2);
    check("pending_cleared_pos", pos_of(0), 2);
    // Reset landing while the move is in JUMP leaves nothing behind.
    bus.roll_req = 1'b1;
    bus.dice_value = 4'd3;
    tick();
    bus.roll_req = 1'b0;
    tick();
    check("pre_reset_add", pos_of(1), 3);
    reset = 1'b1;
    tick();
    check("jump_rst_positions", bus.positions, 0);
    check("jump_rst_cur_player", bus.cur_player, 0);
    check("jump_rst_last_roll", bus.last_roll, 0);
    check("jump_rst_winner", bus.winner, 0);
    check("jump_rst_clear_n", bus.dice_clear_n, 0);
    reset = 1'b0;
    tick();
    tick();
    check("jump_rst_no_done", bus.turn_done, 0);
    check("jump_rst_still_zero", bus.positions, 0);
    // Rolling a six: extra turn only when the feature is built in.
    roll(4'd6);
    check("six_first_pos", pos_of(0), 6);
    check("six_first_player", bus.cur_player, EXTRA ? 0 : 1);
    roll(4'd6);
    check("six_second_p0", pos_of(0), EXTRA ? 12 : 6);
    check("six_second_p1", pos_of(1), EXTRA ? 0 : 6);
    check("six_second_player", bus.cur_player, EXTRA ? 0 : 0);
    do_reset();
    exp_pos[0] = 0;
    exp_pos[1] = 0;
    for (int i = 0; i < 26; i++) begin
      check("turn_player", bus.cur_player, tbl[i].player);
      bus.roll_req = 1'b1;
      bus.dice_value = 4'(tbl[i].dice);
      tick();
      // Keep requesting with a legal value through ADD/JUMP/CHECK; all of these must be dropped.
      bus.dice_value = 4'd3;
      check("accept_last_roll", bus.last_roll, tbl[i].dice);
      tick();
      check("add_pos", pos_of(tbl[i].player), tbl[i].add_pos);
      tick();
      check("jump_pos", pos_of(tbl[i].player), tbl[i].jump_pos);
      check("no_early_done", bus.turn_done, 0);
      exp_pos[tbl[i].player] = tbl[i].jump_pos;
      tick();
      bus.roll_req = 1'b0;
      check("turn_done", bus.turn_done, 1);
      check("winner", bus.winner, tbl[i].win);
      check("next_player", bus.cur_player, tbl[i].win != 0 ? tbl[i].player : 1 - tbl[i].player);
      check("pos_p0", pos_of(0), exp_pos[0]);
      check("pos_p1", pos_of(1), exp_pos[1]);
      tick();
      check("done_one_cycle", bus.turn_done, 0);
      check("dropped_req_roll", bus.last_roll, tbl[i].dice);
      check("dropped_req_pos", bus.positions, {exp_pos[1][6:0], exp_pos[0][6:0]});
    end
    check("win_clear_n", bus.dice_clear_n, 0);
    bus.roll_req = 1'b1;
    bus.dice_value = 4'd2;
    tick();
    tick();
    bus.roll_req = 1'b0;
    tick();
    tick();
    tick();
    check("win_frozen_pos", bus.positions, {exp_pos[1][6:0], exp_pos[0][6:0]});
    check("win_frozen_roll", bus.last_roll, 4);
    check("win_frozen_winner", bus.winner, 2);
    check("win_frozen_done", bus.turn_done, 0);
    check("win_frozen_clear_n", bus.dice_clear_n, 0);
    do_reset();
    check("post_win_reset_winner", bus.winner, 0);
    check("post_win_reset_clear_n", bus.dice_clear_n, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
